intu_cluster_pipe: RTL

//   Parametrised, pipelined SIMT integer execution cluster: NUM_LANES lanes run one warp instruction in lock-step.

---
 rtl/intu_pkg.sv | 34 +++
 rtl/intu_lane_alu.sv | 49 ++++
 rtl/intu_cluster_pipe.sv | 135 +++++++++++++
 3 files changed

// File: rtl/intu_pkg.sv
// Shared definitions for the SIMT integer execution cluster.
// Holds the opcode encoding and the legality check used by the cluster.
// Optional feature macro: INTU_MUL_EN (enables the MUL opcode).
package intu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_MOV  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_SRA  = 4'd8,
    OP_SLT  = 4'd9,
    OP_SLTU = 4'd10,
    OP_MIN  = 4'd11,
    OP_MAX  = 4'd12,
    OP_MUL  = 4'd13
  } intu_op_e;

  // An opcode is legal if it is one of the base ops, or MUL when the
  // multiplier is built in.
  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    legal = (op <= OP_MAX);
`ifdef INTU_MUL_EN
    if (op == OP_MUL) legal = 1'b1;
`endif
    return legal;
  endfunction

endpackage

// File: rtl/intu_lane_alu.sv
// Single-lane combinational integer ALU of the execution cluster.
// An inactive lane (lane_en = 0) produces zero.
// Optional feature macro: INTU_MUL_EN (adds the MUL datapath).
module intu_lane_alu
  import intu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              lane_en,
  output logic [DATA_W-1:0] result
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0]   shamt;
  logic [DATA_W-1:0] raw;

  assign shamt = b[SH_W-1:0];

  // Evaluate the selected operation; undefined opcodes yield zero.
  always_comb begin
    raw = '0;
    case (op)
      OP_ADD:  raw = a + b;
      OP_SUB:  raw = a - b;
      OP_AND:  raw = a & b;
      OP_OR:   raw = a | b;
      OP_XOR:  raw = a ^ b;
      OP_MOV:  raw = b;
      OP_SHL:  raw = a << shamt;
      OP_SHR:  raw = a >> shamt;
      OP_SRA:  raw = $unsigned($signed(a) >>> shamt);
      OP_SLT:  raw = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: raw = {{(DATA_W-1){1'b0}}, (a < b)};
      OP_MIN:  raw = ($signed(a) < $signed(b)) ? a : b;
      OP_MAX:  raw = ($signed(a) > $signed(b)) ? a : b;
`ifdef INTU_MUL_EN
      OP_MUL:  raw = a * b;
`endif
      default: raw = '0;
    endcase
  end

  assign result = lane_en ? raw : '0;

endmodule

// File: rtl/intu_cluster_pipe.sv
// Pipelined SIMT integer execution cluster: NUM_LANES lane ALUs run one
// warp instruction in lock-step, followed by PIPE_DEPTH register stages
// with valid/ready backpressure. The ALU sits ahead of stage 0; later
// stages only delay the packet.
// Optional feature macro: INTU_MUL_EN (MUL opcode; otherwise MUL is illegal).
module intu_cluster_pipe
  import intu_pkg::*;
#(
  parameter int NUM_LANES  = 32,
  parameter int DATA_W     = 32,
  parameter int WARP_W     = 5,
  parameter int REG_W      = 6,
  parameter int PIPE_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WARP_W-1:0]           in_warp,
  input  logic [3:0]                  in_op,
  input  logic [REG_W-1:0]            in_dst,
  input  logic                        in_wr_en,
  input  logic                        in_imm_sel,
  input  logic [DATA_W-1:0]           in_imm,
  input  logic [NUM_LANES-1:0]        in_mask,
  input  logic [NUM_LANES*DATA_W-1:0] in_src_a,
  input  logic [NUM_LANES*DATA_W-1:0] in_src_b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WARP_W-1:0]           out_warp,
  output logic [REG_W-1:0]            out_dst,
  output logic                        out_wr_en,
  output logic                        out_illegal,
  output logic [NUM_LANES-1:0]        out_mask,
  output logic [NUM_LANES*DATA_W-1:0] out_result,
  output logic                        busy
);

  localparam int LW   = NUM_LANES * DATA_W;
  localparam int LAST = PIPE_DEPTH - 1;

  logic          op_legal;
  logic [LW-1:0] alu_result;

  assign op_legal = is_legal_op(in_op);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [DATA_W-1:0] lane_b;
    assign lane_b = in_imm_sel ? in_imm : in_src_b[i*DATA_W +: DATA_W];

    intu_lane_alu #(
      .DATA_W (DATA_W)
    ) u_alu (
      .op      (in_op),
      .a       (in_src_a[i*DATA_W +: DATA_W]),
      .b       (lane_b),
      .lane_en (in_mask[i] & op_legal),
      .result  (alu_result[i*DATA_W +: DATA_W])
    );
  end

  logic [PIPE_DEPTH-1:0] stg_valid;
  logic [PIPE_DEPTH-1:0] stg_adv;
  logic [WARP_W-1:0]     stg_warp    [PIPE_DEPTH];
  logic [REG_W-1:0]      stg_dst     [PIPE_DEPTH];
  logic                  stg_wr_en   [PIPE_DEPTH];
  logic                  stg_illegal [PIPE_DEPTH];
  logic [NUM_LANES-1:0]  stg_mask    [PIPE_DEPTH];
  logic [LW-1:0]         stg_result  [PIPE_DEPTH];

  // Advance chain from the output backwards: a stage moves when it is
  // empty or when the stage after it moves.
  always_comb begin
    logic nxt;
    nxt           = ~stg_valid[LAST] | out_ready;
    stg_adv       = '0;
    stg_adv[LAST] = nxt;
    for (int k = LAST - 1; k >= 0; k--) begin
      nxt        = ~stg_valid[k] | nxt;
      stg_adv[k] = nxt;
    end
  end

  // Stage registers: stage 0 captures ALU output, later stages shift;
  // payload only loads when a valid packet moves in, so it holds on stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      stg_valid <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        stg_warp[k]    <= '0;
        stg_dst[k]     <= '0;
        stg_wr_en[k]   <= 1'b0;
        stg_illegal[k] <= 1'b0;
        stg_mask[k]    <= '0;
        stg_result[k]  <= '0;
      end
    end else begin
      if (stg_adv[0]) begin
        stg_valid[0] <= in_valid;
        if (in_valid) begin
          stg_warp[0]    <= in_warp;
          stg_dst[0]     <= in_dst;
          stg_wr_en[0]   <= in_wr_en & op_legal;
          stg_illegal[0] <= ~op_legal;
          stg_mask[0]    <= in_mask;
          stg_result[0]  <= alu_result;
        end
      end
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        if (stg_adv[k]) begin
          stg_valid[k] <= stg_valid[k-1];
          if (stg_valid[k-1]) begin
            stg_warp[k]    <= stg_warp[k-1];
            stg_dst[k]     <= stg_dst[k-1];
            stg_wr_en[k]   <= stg_wr_en[k-1];
            stg_illegal[k] <= stg_illegal[k-1];
            stg_mask[k]    <= stg_mask[k-1];
            stg_result[k]  <= stg_result[k-1];
          end
        end
      end
    end
  end

  assign in_ready    = stg_adv[0];
  assign busy        = |stg_valid;
  assign out_valid   = stg_valid[LAST];
  assign out_warp    = stg_warp[LAST];
  assign out_dst     = stg_dst[LAST];
  assign out_wr_en   = stg_wr_en[LAST];
  assign out_illegal = stg_illegal[LAST];
  assign out_mask    = stg_mask[LAST];
  assign out_result  = stg_result[LAST];

endmodule
